// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, opcode map and sequencer state encoding.
package alu_pkg;

    localparam int ALU_DATA_W = 16;
    localparam int ALU_OPC_W  = 4;

    localparam int unsigned OP_ADD = 0;
    localparam int unsigned OP_SUB = 1;
    localparam int unsigned OP_AND = 2;
    localparam int unsigned OP_OR  = 3;
    localparam int unsigned OP_XOR = 4;
    localparam int unsigned OP_SHL = 5;
    localparam int unsigned OP_SHR = 6;
    localparam int unsigned OP_MUL = 7;
    localparam int unsigned OP_DIV = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative datapath: shift-add multiply and (with ALU_DIV_EN) restoring divide, one bit per cycle.
// Both ops leave the low word in sh_q and the high word / remainder in acc_q.
module alu_seq_muldiv
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              run_i,
`ifdef ALU_DIV_EN
    input  logic              div_i,
`endif
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              done_o,
    output logic [DATA_W-1:0] lo_o,
    output logic [DATA_W-1:0] hi_o
);

    localparam int CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [DATA_W-1:0] opb_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W:0]   mul_sum;
`ifdef ALU_DIV_EN
    logic [DATA_W:0]   div_trial;
    logic [DATA_W:0]   div_diff;
`endif

    always_comb begin
        // Multiply: add multiplicand into the high word when the current multiplier bit is set.
        mul_sum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opb_q} : '0);
        acc_d   = mul_sum[DATA_W:1];
        sh_d    = {mul_sum[0], sh_q[DATA_W-1:1]};
`ifdef ALU_DIV_EN
        div_trial = {acc_q, sh_q[DATA_W-1]};
        div_diff  = div_trial - {1'b0, opb_q};
        if (div_i) begin
            // A zero divisor always "fits", which yields all-ones quotient and remainder = dividend.
            if (!div_diff[DATA_W]) begin
                acc_d = div_diff[DATA_W-1:0];
                sh_d  = {sh_q[DATA_W-2:0], 1'b1};
            end else begin
                acc_d = div_trial[DATA_W-1:0];
                sh_d  = {sh_q[DATA_W-2:0], 1'b0};
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            sh_q  <= '0;
            opb_q <= '0;
            cnt_q <= '0;
        end else if (start_i) begin
            acc_q <= '0;
            sh_q  <= a_i;
            opb_q <= b_i;
            cnt_q <= '0;
        end else if (run_i) begin
            acc_q <= acc_d;
            sh_q  <= sh_d;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign done_o = run_i && (cnt_q == CNT_W'(DATA_W - 1));
    assign lo_o   = sh_d;
    assign hi_o   = acc_d;

endmodule

// File: rtl/alu_exec.sv
// Execute stage: registered single-cycle ALU ops plus iterative MUL/DIV that stalls upstream.
// Build option ALU_DIV_EN enables the divider for opcode 8; otherwise opcode 8 is illegal.
module alu_exec
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int OPC_W  = ALU_OPC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    input  logic [OPC_W-1:0]  opcode,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] result_hi,
    output logic              res_valid,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_v,
    output logic              illegal
);

    state_t            state_q;
    logic [DATA_W-1:0] result_q, result_hi_q;
    logic              res_valid_q, z_q, c_q, v_q, ill_q;

    logic [DATA_W:0]   sum_w, dif_w;
    logic [DATA_W-1:0] sc_res_d;
    logic              sc_c_d, sc_v_d, sc_ill_d;
    logic              is_mul, is_div, start;
    logic              md_done;
    logic [DATA_W-1:0] md_lo, md_hi;

    always_comb begin
        sum_w    = {1'b0, op1} + {1'b0, op2};
        dif_w    = {1'b0, op1} - {1'b0, op2};
        sc_res_d = '0;
        sc_c_d   = 1'b0;
        sc_v_d   = 1'b0;
        sc_ill_d = 1'b0;
        is_mul   = 1'b0;
        is_div   = 1'b0;
        case (opcode)
            OPC_W'(OP_ADD): begin
                sc_res_d = sum_w[DATA_W-1:0];
                sc_c_d   = sum_w[DATA_W];
                sc_v_d   = (op1[DATA_W-1] == op2[DATA_W-1]) && (sum_w[DATA_W-1] != op1[DATA_W-1]);
            end
            OPC_W'(OP_SUB): begin
                // The borrow out of the widened subtract is exactly op1 < op2 unsigned.
                sc_res_d = dif_w[DATA_W-1:0];
                sc_c_d   = dif_w[DATA_W];
                sc_v_d   = (op1[DATA_W-1] != op2[DATA_W-1]) && (dif_w[DATA_W-1] != op1[DATA_W-1]);
            end
            OPC_W'(OP_AND): sc_res_d = op1 & op2;
            OPC_W'(OP_OR):  sc_res_d = op1 | op2;
            OPC_W'(OP_XOR): sc_res_d = op1 ^ op2;
            OPC_W'(OP_SHL): sc_res_d = op1 << op2[3:0];
            OPC_W'(OP_SHR): sc_res_d = op1 >> op2[3:0];
            OPC_W'(OP_MUL): is_mul = 1'b1;
`ifdef ALU_DIV_EN
            OPC_W'(OP_DIV): is_div = 1'b1;
`endif
            default:        sc_ill_d = 1'b1;
        endcase
    end

    assign in_ready = (state_q == S_IDLE);
    assign start    = in_valid && in_ready && (is_mul || is_div);

    alu_seq_muldiv #(
        .DATA_W (DATA_W)
    ) u_muldiv (
        .clk     (clk),
        .reset   (reset),
        .start_i (start),
        .run_i   (state_q != S_IDLE),
`ifdef ALU_DIV_EN
        .div_i   (state_q == S_DIV),
`endif
        .a_i     (op1),
        .b_i     (op2),
        .done_o  (md_done),
        .lo_o    (md_lo),
        .hi_o    (md_hi)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            res_valid_q <= 1'b0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        if (is_mul) begin
                            state_q <= S_MUL;
                        end else if (is_div) begin
                            state_q <= S_DIV;
                        end else begin
                            result_q    <= sc_res_d;
                            result_hi_q <= '0;
                            z_q         <= (sc_res_d == '0);
                            c_q         <= sc_c_d;
                            v_q         <= sc_v_d;
                            ill_q       <= sc_ill_d;
                            res_valid_q <= 1'b1;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (md_done) begin
                        result_q    <= md_lo;
                        result_hi_q <= md_hi;
                        // MUL tests the full double-width product; DIV only the quotient.
                        z_q         <= (state_q == S_MUL) ? ({md_hi, md_lo} == '0) : (md_lo == '0);
                        c_q         <= 1'b0;
                        v_q         <= 1'b0;
                        ill_q       <= 1'b0;
                        res_valid_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign res_valid = res_valid_q;
    assign flag_z    = z_q;
    assign flag_c    = c_q;
    assign flag_v    = v_q;
    assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: directed vectors, an arithmetic reference model with a latency-aware
// scoreboard checked every cycle, and literal expectations for the headline cases.
module tb_alu_exec;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] op1 = '0;
    logic [15:0] op2 = '0;
    logic [3:0]  opcode = '0;
    logic [15:0] result, result_hi;
    logic        res_valid, flag_z, flag_c, flag_v, illegal;

    alu_exec dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .opcode    (opcode),
        .result    (result),
        .result_hi (result_hi),
        .res_valid (res_valid),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        bit          multi;
        logic [15:0] lo;
        logic [15:0] hi;
        logic        z, c, v, ill;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    int          edge_n = 0;
    int          acc_edge = 0;
    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] h_out = '0;
    logic [3:0]  h_flg = '0;
    logic        exp_rdy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference behaviour in plain arithmetic; latency 0 means "visible right after the accept edge".
    function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        exp_t   e;
        longint p;
        int     sa, sb, sr, n;
        e.due = 0; e.multi = 1'b0; e.lo = '0; e.hi = '0;
        e.z = 1'b0; e.c = 1'b0; e.v = 1'b0; e.ill = 1'b0;
        sa = int'($signed(a));
        sb = int'($signed(b));
        n  = int'(b[3:0]);
        p  = 0;
        case (op)
            4'd0: begin
                p = longint'(a) + longint'(b);
                e.lo = p[15:0]; e.c = p[16];
                sr = sa + sb; e.v = (sr > 32767) || (sr < -32768);
            end
            4'd1: begin
                p = longint'(a) - longint'(b);
                e.lo = p[15:0]; e.c = (a < b);
                sr = sa - sb; e.v = (sr > 32767) || (sr < -32768);
            end
            4'd2: e.lo = a & b;
            4'd3: e.lo = a | b;
            4'd4: e.lo = a ^ b;
            4'd5: begin
                p = longint'(a);
                for (int k = 0; k < n; k++) p = p * 2;
                e.lo = p[15:0];
            end
            4'd6: begin
                p = longint'(a);
                for (int k = 0; k < n; k++) p = p / 2;
                e.lo = p[15:0];
            end
            4'd7: begin
                p = longint'(a) * longint'(b);
                e.lo = p[15:0]; e.hi = p[31:16]; e.multi = 1'b1;
            end
`ifdef ALU_DIV_EN
            4'd8: begin
                e.multi = 1'b1;
                if (b == 16'h0) begin e.lo = 16'hFFFF; e.hi = a; end
                else begin e.lo = a / b; e.hi = a % b; end
            end
`endif
            default: e.ill = 1'b1;
        endcase
        e.z = ({e.hi, e.lo} == 32'h0);
        if (op == 4'd8) e.z = (e.lo == 16'h0);
        return e;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
        end else begin
            edge_n = edge_n + 1;
            if (in_valid && in_ready) begin
                cur = model(opcode, op1, op2);
                cur.due = edge_n + (cur.multi ? 16 : 0);
                exp_q.push_back(cur);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("reset_outputs", {result_hi, result}, 32'h0);
            chk("reset_flags", 32'({res_valid, flag_z, flag_c, flag_v, illegal}), 32'h0);
            chk("reset_in_ready", 32'(in_ready), 32'd1);
            h_out = '0;
            h_flg = '0;
        end else begin
            exp_rdy = 1'b1;
            foreach (exp_q[i]) if (exp_q[i].multi && exp_q[i].due > edge_n) exp_rdy = 1'b0;
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            if (exp_q.size() > 0 && exp_q[0].due <= edge_n) begin
                cur = exp_q.pop_front();
                chk("res_valid_pulse", 32'(res_valid), 32'd1);
                chk("result_pair", {result_hi, result}, {cur.hi, cur.lo});
                chk("flags_zcvi", 32'({flag_z, flag_c, flag_v, illegal}), 32'({cur.z, cur.c, cur.v, cur.ill}));
                h_out = {cur.hi, cur.lo};
                h_flg = {cur.z, cur.c, cur.v, cur.ill};
            end else begin
                chk("res_valid_idle", 32'(res_valid), 32'd0);
                chk("hold_result", {result_hi, result}, h_out);
                chk("hold_flags", 32'({flag_z, flag_c, flag_v, illegal}), 32'(h_flg));
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        in_valid = 1'b1; opcode = op; op1 = a; op2 = b;
        for (int w = 0; w < 40 && in_ready !== 1'b1; w++) @(negedge clk);
        chk("issue_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        acc_edge = edge_n;
        in_valid = 1'b0;
        op1 = 16'($urandom); op2 = 16'($urandom); opcode = 4'($urandom);
    endtask

    task automatic wait_res(output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (res_valid !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("result_arrives", 32'(res_valid), 32'd1);
        lat = edge_n - acc_edge;
    endtask

    logic [3:0]  t_op [0:16] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd5,
                                 4'd7, 4'd0, 4'd7, 4'd8, 4'd8, 4'd9, 4'd15, 4'd0};
    logic [15:0] t_a  [0:16] = '{16'h0000, 16'h8000, 16'h0005, 16'hF0F0, 16'hF0F0, 16'hAAAA, 16'h8001, 16'h8001, 16'h0001,
                                 16'hFFFF, 16'h1111, 16'h0000, 16'h0007, 16'h0000, 16'h1234, 16'h5678, 16'h8000};
    logic [15:0] t_b  [0:16] = '{16'h0000, 16'h0001, 16'h0005, 16'h3C3C, 16'h0F0F, 16'hAAAA, 16'h000F, 16'h0000, 16'hFFF1,
                                 16'hFFFF, 16'h2222, 16'h1234, 16'h0003, 16'h0005, 16'h4321, 16'h8765, 16'h8000};

    initial begin
        int lat, mul_edge;
        #1 reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom); opcode = 4'($urandom);
            op1 = 16'($urandom); op2 = 16'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1 reset = 1'b1;

        issue(4'd0, 16'h7FFF, 16'h0001); wait_res(lat);
        chk("add_ovf_result", 32'(result), 32'h8000);
        chk("add_ovf_zcvi", 32'({flag_z, flag_c, flag_v, illegal}), 32'b0010);
        chk("add_latency", 32'(lat), 32'd0);
        issue(4'd0, 16'hFFFF, 16'h0001); wait_res(lat);
        chk("add_carry_result", 32'(result), 32'h0000);
        chk("add_carry_zcvi", 32'({flag_z, flag_c, flag_v, illegal}), 32'b1100);
        issue(4'd1, 16'h0050, 16'h0F00); wait_res(lat);
        chk("sub_borrow_result", 32'(result), 32'hF150);
        chk("sub_borrow_zcvi", 32'({flag_z, flag_c, flag_v, illegal}), 32'b0100);
        issue(4'd5, 16'h00FF, 16'h0004); wait_res(lat);
        chk("shl_result", 32'(result), 32'h0FF0);
        issue(4'd6, 16'hFF88, 16'h0003); wait_res(lat);
        chk("shr_result", 32'(result), 32'h1FF1);
        issue(4'd7, 16'h0F00, 16'h0050); wait_res(lat);
        chk("mul_product", {result_hi, result}, 32'h0004_B000);
        chk("mul_latency", 32'(lat), 32'd16);
`ifdef ALU_DIV_EN
        issue(4'd8, 16'hFF0F, 16'h0040); wait_res(lat);
        chk("div_quot_rem", {result_hi, result}, 32'h000F_03FC);
        chk("div_latency", 32'(lat), 32'd16);
        issue(4'd8, 16'h1234, 16'h0000); wait_res(lat);
        chk("div_by_zero", {result_hi, result}, 32'h1234_FFFF);
`else
        issue(4'd8, 16'hFF0F, 16'h0040); wait_res(lat);
        chk("op8_illegal_result", {result_hi, result}, 32'h0);
        chk("op8_illegal_zcvi", 32'({flag_z, flag_c, flag_v, illegal}), 32'b1001);
        chk("op8_latency", 32'(lat), 32'd0);
`endif
        issue(4'd12, 16'h1234, 16'h5678); wait_res(lat);
        chk("opc_illegal_result", {result_hi, result}, 32'h0);
        chk("opc_illegal_zcvi", 32'({flag_z, flag_c, flag_v, illegal}), 32'b1001);

        // MUL immediately followed by ADD held upstream during the iteration.
        issue(4'd7, 16'h0F00, 16'h0050);
        mul_edge = acc_edge;
        issue(4'd0, 16'h0003, 16'h0004); wait_res(lat);
        chk("b2b_accept_edge", 32'(acc_edge - mul_edge), 32'd17);
        chk("b2b_add_result", 32'(result), 32'h0007);

        for (int i = 0; i < 17; i++) issue(t_op[i], t_a[i], t_b[i]);
        repeat (40) @(negedge clk);

        issue(4'd0, 16'h1234, 16'h0001); wait_res(lat);
        chk("pre_abort_result", 32'(result), 32'h1235);
        issue(4'd7, 16'h00FF, 16'h00FF);
        repeat (5) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_clears_result", {result_hi, result}, 32'h0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_no_valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        repeat (25) @(negedge clk);
        issue(4'd4, 16'h0F0F, 16'hFFFF); wait_res(lat);
        chk("post_abort_xor", 32'(result), 32'hF0F0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
